// File: rtl/cmd_issuer.sv
// cmd_issuer: sequences one command/response exchange with a UART-attached
// hash engine.
//   Opcode 8'h01 sends the opcode and 16 hash bytes, then waits for an ACK byte.
//   Opcode 8'h02 sends the opcode, a 16-bit length and the streamed payload,
//   then waits for an ACK byte.
//   Opcode 8'h03 sends the opcode, then receives a 2-byte position and
//   19 characters.
// Ports
//   clk, reset (async, active-low)
//   cmd_start/cmd_op/cmd_hash/cmd_num_bytes : command request and arguments
//   data_in/data_valid/data_ready           : payload stream for opcode 8'h02
//   txd_start/txd_data/txd_busy             : UART transmit handshake
//   rxd_data/rxd_data_ready                 : UART receive strobe
//   busy/done/status                        : command progress and result
//   rsp_pos/rsp_char/rsp_char_valid         : match response for opcode 8'h03
//   leds                                    : current state code, for debug
//
// state    | meaning
// IDLE     | waiting for cmd_start
// TX_OP    | send opcode byte
// TX_HASH  | send 16 hash bytes, MSB first
// TX_LEN   | send 16-bit payload length, MSB first
// TX_DATA  | forward payload bytes from data_in
// RX_ACK   | wait for ACK/NACK byte
// RX_POS   | receive 2-byte match position
// RX_CHARS | receive 19 match characters
// FINISH   | one-cycle done pulse, back to IDLE
module cmd_issuer #(
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic [7:0]   cmd_op,
  input  logic [127:0] cmd_hash,
  input  logic [15:0]  cmd_num_bytes,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic         txd_busy,
  output logic         txd_start,
  output logic [7:0]   txd_data,
  input  logic [7:0]   rxd_data,
  input  logic         rxd_data_ready,
  output logic         busy,
  output logic         done,
  output logic [1:0]   status,
  output logic [15:0]  rsp_pos,
  output logic [7:0]   rsp_char,
  output logic         rsp_char_valid,
  output logic [7:0]   leds
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] TX_OP    = 4'd1;
  localparam logic [3:0] TX_HASH  = 4'd2;
  localparam logic [3:0] TX_LEN   = 4'd3;
  localparam logic [3:0] TX_DATA  = 4'd4;
  localparam logic [3:0] RX_ACK   = 4'd5;
  localparam logic [3:0] RX_POS   = 4'd6;
  localparam logic [3:0] RX_CHARS = 4'd7;
  localparam logic [3:0] FINISH   = 4'd8;

  // Transmit slot tracking: after a strobe, the UART must be seen busy and
  // then idle again before the next byte may be issued.
  localparam logic [1:0] TXP_READY   = 2'd0;
  localparam logic [1:0] TXP_WAIT_HI = 2'd1;
  localparam logic [1:0] TXP_WAIT_LO = 2'd2;

  logic [3:0]   state_q, state_d;
  logic [7:0]   op_q, op_d;
  logic [127:0] hash_q, hash_d;
  logic [15:0]  num_q, num_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [23:0]  tmo_q, tmo_d;
  logic [1:0]   txp_q, txp_d;
  logic         txd_start_q, txd_start_d;
  logic [7:0]   txd_data_q, txd_data_d;
  logic [1:0]   status_q, status_d;
  logic [15:0]  rsp_pos_q, rsp_pos_d;
  logic [7:0]   rsp_char_q, rsp_char_d;
  logic         rsp_char_valid_q, rsp_char_valid_d;

  logic         slot_free, in_rx, rx_hit, tmo_exp, issue;
  logic [7:0]   issue_byte;

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    hash_d           = hash_q;
    num_d            = num_q;
    cnt_d            = cnt_q;
    txp_d            = txp_q;
    txd_start_d      = 1'b0;
    txd_data_d       = txd_data_q;
    status_d         = status_q;
    rsp_pos_d        = rsp_pos_q;
    rsp_char_d       = rsp_char_q;
    rsp_char_valid_d = 1'b0;
    issue            = 1'b0;
    issue_byte       = 8'h00;

    slot_free  = (txp_q == TXP_READY) && !txd_busy;
    in_rx      = (state_q == RX_ACK) || (state_q == RX_POS) || (state_q == RX_CHARS);
    rx_hit     = in_rx && rxd_data_ready;
    // A byte arriving on the expiry cycle wins over the timeout.
    tmo_exp    = in_rx && !rxd_data_ready && (tmo_q == TIMEOUT - 24'd1);
    data_ready = (state_q == TX_DATA) && slot_free;

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_op == 8'h01 || cmd_op == 8'h02 || cmd_op == 8'h03) begin
            op_d      = cmd_op;
            hash_d    = cmd_hash;
            num_d     = cmd_num_bytes;
            cnt_d     = 16'd0;
            status_d  = 2'd0;
            rsp_pos_d = 16'h0000;
            state_d   = TX_OP;
          end else begin
            status_d = 2'd3;
            state_d  = FINISH;
          end
        end
      end
      TX_OP: begin
        if (slot_free) begin
          issue      = 1'b1;
          issue_byte = op_q;
          cnt_d      = 16'd0;
          case (op_q)
            8'h01:   state_d = TX_HASH;
            8'h02:   state_d = TX_LEN;
            default: state_d = RX_POS;
          endcase
        end
      end
      TX_HASH: begin
        if (slot_free) begin
          issue      = 1'b1;
          issue_byte = hash_q[127:120];
          hash_d     = {hash_q[119:0], 8'h00};
          if (cnt_q == 16'd15) begin
            cnt_d   = 16'd0;
            state_d = RX_ACK;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      TX_LEN: begin
        if (slot_free) begin
          issue = 1'b1;
          if (cnt_q[0]) begin
            issue_byte = num_q[7:0];
            cnt_d      = 16'd0;
            state_d    = (num_q == 16'd0) ? RX_ACK : TX_DATA;
          end else begin
            issue_byte = num_q[15:8];
            cnt_d      = 16'd1;
          end
        end
      end
      TX_DATA: begin
        if (data_valid && data_ready) begin
          issue      = 1'b1;
          issue_byte = data_in;
          if (cnt_q + 16'd1 == num_q) begin
            cnt_d   = 16'd0;
            state_d = RX_ACK;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      RX_ACK: begin
        if (rx_hit) begin
          case (rxd_data)
            8'h01:   status_d = 2'd0;
            8'h00:   status_d = 2'd1;
            default: status_d = 2'd3;
          endcase
          state_d = FINISH;
        end else if (tmo_exp) begin
          status_d = 2'd2;
          state_d  = FINISH;
        end
      end
      RX_POS: begin
        if (rx_hit) begin
          if (cnt_q[0]) begin
            rsp_pos_d[7:0] = rxd_data;
            cnt_d          = 16'd0;
            state_d        = RX_CHARS;
          end else begin
            rsp_pos_d[15:8] = rxd_data;
            cnt_d           = 16'd1;
          end
        end else if (tmo_exp) begin
          status_d = 2'd2;
          state_d  = FINISH;
        end
      end
      RX_CHARS: begin
        if (rx_hit) begin
          rsp_char_d       = rxd_data;
          rsp_char_valid_d = 1'b1;
          if (cnt_q == 16'd18) begin
            cnt_d    = 16'd0;
            status_d = 2'd0;
            state_d  = FINISH;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (tmo_exp) begin
          status_d = 2'd2;
          state_d  = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (txp_q)
      TXP_WAIT_HI: if (txd_busy)  txp_d = TXP_WAIT_LO;
      TXP_WAIT_LO: if (!txd_busy) txp_d = TXP_READY;
      default:     txp_d = TXP_READY;
    endcase
    if (issue) begin
      txd_start_d = 1'b1;
      txd_data_d  = issue_byte;
      txp_d       = TXP_WAIT_HI;
    end

    // Timer runs only while staying in an RX state with no byte arriving;
    // state entry and every received byte restart it.
    tmo_d = (in_rx && (state_d == state_q) && !rxd_data_ready) ? tmo_q + 24'd1 : 24'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      op_q             <= 8'h00;
      hash_q           <= 128'h0;
      num_q            <= 16'h0000;
      cnt_q            <= 16'h0000;
      tmo_q            <= 24'h0;
      txp_q            <= TXP_READY;
      txd_start_q      <= 1'b0;
      txd_data_q       <= 8'h00;
      status_q         <= 2'd0;
      rsp_pos_q        <= 16'h0000;
      rsp_char_q       <= 8'h00;
      rsp_char_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      hash_q           <= hash_d;
      num_q            <= num_d;
      cnt_q            <= cnt_d;
      tmo_q            <= tmo_d;
      txp_q            <= txp_d;
      txd_start_q      <= txd_start_d;
      txd_data_q       <= txd_data_d;
      status_q         <= status_d;
      rsp_pos_q        <= rsp_pos_d;
      rsp_char_q       <= rsp_char_d;
      rsp_char_valid_q <= rsp_char_valid_d;
    end
  end

  assign txd_start      = txd_start_q;
  assign txd_data       = txd_data_q;
  assign status         = status_q;
  assign rsp_pos        = rsp_pos_q;
  assign rsp_char       = rsp_char_q;
  assign rsp_char_valid = rsp_char_valid_q;
  assign busy           = (state_q != IDLE) && (state_q != FINISH);
  assign done           = (state_q == FINISH);
  assign leds           = {4'b0000, state_q};

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed bench for cmd_issuer: UART model holds txd_busy for 10 cycles per
// byte and records every transmitted byte; responses are injected by hand.
module tb_cmd_issuer;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_start;
  logic [7:0]   cmd_op;
  logic [127:0] cmd_hash;
  logic [15:0]  cmd_num_bytes;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_ready;
  logic         txd_busy;
  logic         txd_start;
  logic [7:0]   txd_data;
  logic [7:0]   rxd_data;
  logic         rxd_data_ready;
  logic         busy;
  logic         done;
  logic [1:0]   status;
  logic [15:0]  rsp_pos;
  logic [7:0]   rsp_char;
  logic         rsp_char_valid;
  logic [7:0]   leds;

  localparam logic [7:0] S_IDLE   = 8'd0;
  localparam logic [7:0] S_RX_ACK = 8'd5;
  localparam logic [7:0] S_RX_POS = 8'd6;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int viol = 0;
  int start_cyc = 0;
  logic [7:0] txq[$];
  int         tcyc[$];
  logic [7:0] rq[$];

  cmd_issuer #(.TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_op(cmd_op),
    .cmd_hash(cmd_hash), .cmd_num_bytes(cmd_num_bytes), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .txd_busy(txd_busy),
    .txd_start(txd_start), .txd_data(txd_data), .rxd_data(rxd_data),
    .rxd_data_ready(rxd_data_ready), .busy(busy), .done(done), .status(status),
    .rsp_pos(rsp_pos), .rsp_char(rsp_char), .rsp_char_valid(rsp_char_valid),
    .leds(leds)
  );

  always #5 clk = ~clk;

  assign txd_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txd_start) begin
      if (txd_busy) viol <= viol + 1;
      txq.push_back(txd_data);
      tcyc.push_back(cyc);
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (rsp_char_valid) rq.push_back(rsp_char);
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic [7:0] op, input logic [127:0] h, input logic [15:0] n);
    @(negedge clk);
    cmd_op = op; cmd_hash = h; cmd_num_bytes = n; cmd_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rxd_data = b; rxd_data_ready = 1'b1;
    @(negedge clk);
    rxd_data_ready = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int maxc);
    int k = 0;
    while (txq.size() < n && k < maxc) begin @(negedge clk); k++; end
    chk("tx_count_reached", txq.size() >= n, 1'b1);
  endtask

  task automatic wait_state(input logic [7:0] s, input int maxc);
    int k = 0;
    while (leds != s && k < maxc) begin @(negedge clk); k++; end
    chk("state_reached", leds, s);
  endtask

  task automatic wait_done(input int maxc, output int k);
    k = 0;
    while (!done && k < maxc) begin @(negedge clk); k++; end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic send_payload(input logic [7:0] b);
    int k = 0;
    data_in = b; data_valid = 1'b1;
    while (!data_ready && k < 100) begin @(negedge clk); k++; end
    chk("payload_ready", data_ready, 1'b1);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] h1, h2;
    string s;
    int base, rbase, k, e;
    h1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    h2 = 128'hFEDCBA98765432100011223344556677;
    s  = "The quick brown fox";
    reset = 1'b0; cmd_start = 1'b0; cmd_op = 8'h00; cmd_hash = '0; cmd_num_bytes = 16'h0;
    data_in = 8'h00; data_valid = 1'b0; rxd_data = 8'h00; rxd_data_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd_start", txd_start, 1'b0);
    chk("rst_outputs", {busy, done, data_ready, rsp_char_valid, status, rsp_pos, rsp_char, txd_data, leds}, '0);
    reset = 1'b1;
    @(negedge clk);

    // set hash, ACK
    base = txq.size();
    issue_cmd(8'h01, h1, 16'h0);
    chk("sethash_busy", busy, 1'b1);
    wait_tx(base + 17, 600);
    chk("sethash_latency", (tcyc[base] - start_cyc) >= 2, 1'b1);
    chk("sethash_op", txq[base], 8'h01);
    for (int i = 0; i < 16; i++) chk($sformatf("sethash_b%0d", i), txq[base + 1 + i], h1[127 - 8*i -: 8]);
    wait_state(S_RX_ACK, 50);
    send_rx(8'h01);
    chk("sethash_done", done, 1'b1);
    chk("sethash_status", status, 2'd0);
    chk("sethash_busy_fin", busy, 1'b0);
    @(negedge clk);
    chk("sethash_done_pulse", done, 1'b0);
    chk("sethash_tx_total", txq.size(), base + 17);

    // rx strobe while idle has no effect
    send_rx(8'h55);
    @(negedge clk);
    chk("idle_rx_state", leds, S_IDLE);
    chk("idle_rx_status", status, 2'd0);
    chk("idle_rx_done", done, 1'b0);

    // process chars with a mid-payload stall, NACK
    base = txq.size();
    issue_cmd(8'h02, '0, 16'h0003);
    chk("proc_ready_early", data_ready, 1'b0);
    send_payload(8'h41);
    repeat (20) @(negedge clk);
    send_payload(8'h42);
    send_payload(8'h43);
    wait_tx(base + 6, 200);
    chk("proc_b0", txq[base + 0], 8'h02);
    chk("proc_b1", txq[base + 1], 8'h00);
    chk("proc_b2", txq[base + 2], 8'h03);
    chk("proc_b3", txq[base + 3], 8'h41);
    chk("proc_b4", txq[base + 4], 8'h42);
    chk("proc_b5", txq[base + 5], 8'h43);
    wait_state(S_RX_ACK, 50);
    send_rx(8'h00);
    chk("proc_done", done, 1'b1);
    chk("proc_status", status, 2'd1);
    chk("proc_tx_total", txq.size(), base + 6);

    // return match
    base = txq.size();
    rbase = rq.size();
    issue_cmd(8'h03, '0, 16'h0);
    wait_tx(base + 1, 100);
    chk("match_op", txq[base], 8'h03);
    wait_state(S_RX_POS, 50);
    send_rx(8'h00);
    send_rx(8'h2A);
    send_rx(s[0]);
    chk("match_char0_valid", rsp_char_valid, 1'b1);
    chk("match_char0", rsp_char, s[0]);
    for (int i = 1; i < 19; i++) send_rx(s[i]);
    chk("match_done", done, 1'b1);
    chk("match_status", status, 2'd0);
    chk("match_pos", rsp_pos, 16'h002A);
    repeat (3) @(negedge clk);
    chk("match_nchars", rq.size() - rbase, 19);
    for (int i = 0; i < 19; i++) chk($sformatf("match_c%0d", i), rq[rbase + i], s[i]);
    chk("match_pos_hold", rsp_pos, 16'h002A);

    // set hash, no response -> timeout exactly 100 cycles after RX_ACK entry
    issue_cmd(8'h01, h1, 16'h0);
    wait_state(S_RX_ACK, 600);
    e = 0;
    while (!done && e < 300) begin @(negedge clk); e++; end
    chk("tmo_cycles", e, 100);
    chk("tmo_status", status, 2'd2);

    // set hash, bad ACK byte -> protocol error
    base = txq.size();
    issue_cmd(8'h01, h1, 16'h0);
    wait_tx(base + 17, 600);
    wait_state(S_RX_ACK, 50);
    send_rx(8'h55);
    chk("badack_done", done, 1'b1);
    chk("badack_status", status, 2'd3);

    // bad opcode
    base = txq.size();
    issue_cmd(8'h07, '0, 16'h0);
    wait_done(2, k);
    chk("badop_status", status, 2'd3);
    chk("badop_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    chk("badop_no_tx", txq.size(), base);

    // cmd_start while busy is ignored
    base = txq.size();
    issue_cmd(8'h03, '0, 16'h0);
    wait_state(S_RX_POS, 100);
    issue_cmd(8'h01, h2, 16'h0);
    wait_done(200, k);
    chk("ignore_status", status, 2'd2);
    repeat (40) @(negedge clk);
    chk("ignore_tx", txq.size(), base + 1);
    chk("ignore_idle", leds, S_IDLE);

    // reset in the middle of the hash, while the 5th byte strobe is high
    base = txq.size();
    issue_cmd(8'h01, h1, 16'h0);
    k = 0;
    while (!(txd_start && txq.size() == base + 4) && k < 400) begin @(negedge clk); k++; end
    chk("midrst_reached", txd_start, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_txd_start", txd_start, 1'b0);
    chk("midrst_busy_done", {busy, done}, 2'b00);
    chk("midrst_state", leds, S_IDLE);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_quiet", txq.size(), base + 4);
    base = txq.size();
    issue_cmd(8'h01, h2, 16'h0);
    wait_tx(base + 17, 600);
    chk("postrst_op", txq[base], 8'h01);
    for (int i = 0; i < 16; i++) chk($sformatf("postrst_b%0d", i), txq[base + 1 + i], h2[127 - 8*i -: 8]);
    wait_state(S_RX_ACK, 50);
    send_rx(8'h01);
    chk("postrst_done", done, 1'b1);
    chk("postrst_status", status, 2'd0);

    chk("uart_protocol", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
